// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one 4-bit full-adder slice is reused once per clock,
// least-significant nibble first, behind a start/busy/done handshake.

module nibble_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] low;
    logic [1:0] high;

    // The low three bits are summed separately so the carry into bit 3 is visible for V.
    assign low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
    assign high = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low[3]};
    assign s    = {high[0], low[2:0]};
    assign co   = high[1];
    assign c3   = low[3];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 V
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = $clog2(NIBBLES);
    localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    shadow;
    logic [W-1:0]    sum_next;
    logic            carry;
    logic [KW-1:0]   k;
    logic [3:0]      slice_a;
    logic [3:0]      slice_b;
    logic [3:0]      slice_s;
    logic            slice_co;
    logic            slice_c3;

    assign slice_a = a_q[k*4 +: 4];
    assign slice_b = b_q[k*4 +: 4];

    nibble_adder4 u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    // Shadow sum with the current nibble merged in, so completion can publish it directly.
    always_comb begin
        sum_next = shadow;
        sum_next[k*4 +: 4] = slice_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            S      <= '0;
            Cout   <= 1'b0;
            V      <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            k      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= Cin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    shadow <= sum_next;
                    carry  <= slice_co;
                    if (k == LAST) begin
                        S     <= sum_next;
                        Cout  <= slice_co;
                        V     <= slice_c3 ^ slice_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
